store_buffer: RTL and testbench

Write-side counterpart of the processor's load path. It accepts store requests (SB/SH/SW) from the core's EXECUTE stage and converts each byte address and `funct3` into a word-aligned address, replicated write data and a 4-bit byte mask. Accepted stores are queued in a small FIFO and drained to memory over a valid/busy write port. The core checks `empty` before issuing a load, so loads never pass pending stores.

---
 rtl/store_buffer.sv | 131 +++++++++++++
 tb/tb_store_buffer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// store_buffer: aligns SB/SH/SW requests into word address, lane data and
// byte mask, then queues them for strictly in-order drain to memory.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [31:0]              st_addr,
  input  logic [31:0]              st_data,
  input  logic [2:0]               st_funct3,
  output logic                     st_err,
  output logic [31:0]              mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_wmask,
  output logic                     mem_wstrb,
  input  logic                     mem_wbusy,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } entry_t;

  entry_t        fifo [DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          legal;
  logic [31:0]   al_data;
  logic [3:0]    al_mask;
  logic          full;
  logic          push;
  logic          push_ok;
  logic          pop;
  logic          unused;

  // funct3[2] only distinguishes signed loads; stores ignore it
  assign unused = st_funct3[2];

  assign full      = count == CW'(DEPTH);
  assign empty     = count == '0;
  assign st_ready  = !full;
  assign mem_wstrb = !empty;
  assign push      = st_valid && st_ready;
  assign push_ok   = push && legal;
  assign pop       = mem_wstrb && !mem_wbusy;

  assign head      = fifo[rd_ptr];
  assign mem_addr  = {head.waddr, 2'b00};
  assign mem_wdata = head.wdata;
  assign mem_wmask = empty ? 4'b0000 : head.wmask;

  // size/offset decode into replicated lane data and byte mask
  always_comb begin
    legal   = 1'b0;
    al_data = st_data;
    al_mask = 4'b0000;
    unique case (st_funct3[1:0])
      2'b00: begin
        legal   = 1'b1;
        al_data = {4{st_data[7:0]}};
        al_mask = 4'b0001 << st_addr[1:0];
      end
      2'b01: begin
        legal   = !st_addr[0];
        al_data = {2{st_data[15:0]}};
        al_mask = st_addr[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        legal   = st_addr[1:0] == 2'b00;
        al_data = st_data;
        al_mask = 4'b1111;
      end
      default: begin
        legal   = 1'b0;
        al_data = st_data;
        al_mask = 4'b0000;
      end
    endcase
  end

  // entry storage; only legal accepted stores are written
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) fifo[i] <= '0;
    end else if (push_ok) begin
      fifo[wr_ptr] <= '{waddr: st_addr[31:2],
                        wdata: al_data,
                        wmask: al_mask};
    end
  end

  // pointers wrap naturally at DEPTH (power of two)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // occupancy; simultaneous push and pop leave it unchanged
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else begin
      unique case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // one-cycle pulse after a dropped misaligned/illegal store
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) st_err <= 1'b0;
    else         st_err <= push && !legal;
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: scoreboard bench for store_buffer with a byte-lane model.
// Directed cases first, then randomized traffic with random write stalls.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk;
  logic        resetn;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_wstrb;
  logic        mem_wbusy;
  logic        empty;
  logic [$clog2(DEPTH):0] count;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .st_err(st_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_wstrb(mem_wstrb), .mem_wbusy(mem_wbusy),
    .empty(empty), .count(count)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } exp_t;

  exp_t q[$];
  bit   err_pend;
  int   checks;
  int   failures;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // byte-lane view: size n bytes at offset a; lane i carries data byte i%n
  function automatic void model(input logic [31:0] addr,
                                input logic [31:0] data,
                                input logic [2:0]  f3,
                                output bit ok, output exp_t e);
    int n;
    int a;
    n  = 1 << f3[1:0];
    a  = int'(addr[1:0]);
    ok = (f3[1:0] != 2'b11) && (a % n == 0);
    e.a = addr & 32'hFFFF_FFFC;
    e.d = '0;
    e.m = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= a && i < a + n) e.m[i] = 1'b1;
      e.d[8*i +: 8] = data[8*(i % n) +: 8];
    end
  endfunction

  // reference: record what the next rising edge will accept
  always @(negedge clk) begin
    bit   ok;
    exp_t e;
    #1;
    if (!resetn) begin
      q.delete();
      err_pend = 1'b0;
    end else if (st_valid && st_ready) begin
      model(st_addr, st_data, st_funct3, ok, e);
      if (ok) q.push_back(e);
      err_pend = !ok;
    end else begin
      err_pend = 1'b0;
    end
  end

  // monitor: compare presented state/head entry, retire on each pop
  always @(negedge clk) begin
    if (resetn) begin
      chk("st_err", {31'b0, st_err}, {31'b0, err_pend});
      chk("count", 32'(count), 32'(q.size()));
      chk("empty", {31'b0, empty}, {31'b0, q.size() == 0});
      chk("st_ready", {31'b0, st_ready}, {31'b0, q.size() < DEPTH});
      chk("mem_wstrb", {31'b0, mem_wstrb}, {31'b0, q.size() != 0});
      if (q.size() == 0) begin
        chk("wmask_empty", {28'b0, mem_wmask}, 32'h0);
      end else begin
        chk("mem_addr", mem_addr, q[0].a);
        chk("mem_wdata", mem_wdata, q[0].d);
        chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, q[0].m});
        if (mem_wstrb && !mem_wbusy) void'(q.pop_front());
      end
    end
  end

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3);
    st_valid  = 1'b1;
    st_addr   = a;
    st_data   = d;
    st_funct3 = f3;
  endtask

  task automatic wait_accept();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!st_ready && n < 50);
    chk("accept_timeout", {31'b0, st_ready}, 32'h1);
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] f3);
    drive(a, d, f3);
    wait_accept();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    checks    = 0;
    failures  = 0;
    resetn    = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_funct3 = '0;
    mem_wbusy = 1'b0;
    #3;
    chk("rst_empty", {31'b0, empty}, 32'h1);
    chk("rst_ready", {31'b0, st_ready}, 32'h1);
    chk("rst_wstrb", {31'b0, mem_wstrb}, 32'h0);
    chk("rst_wmask", {28'b0, mem_wmask}, 32'h0);
    chk("rst_err", {31'b0, st_err}, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    idle(1);

    store(32'h192, 32'h0000_00A5, 3'b000);
    chk("sb_addr", mem_addr, 32'h190);
    chk("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_wmask", {28'b0, mem_wmask}, 32'h4);
    chk("sb_count", 32'(count), 32'h1);
    idle(1);
    chk("sb_retired", {31'b0, empty}, 32'h1);

    store(32'h1A2, 32'h0000_1234, 3'b001);
    chk("sh_wdata", mem_wdata, 32'h1234_1234);
    chk("sh_wmask", {28'b0, mem_wmask}, 32'hC);
    store(32'h1A4, 32'hDEAD_BEEF, 3'b010);
    chk("sw_addr", mem_addr, 32'h1A4);
    chk("sw_wmask", {28'b0, mem_wmask}, 32'hF);
    idle(2);

    mem_wbusy = 1'b1;
    for (int i = 1; i <= 4; i++) store(32'h300 + 32'(4*i), 32'(i), 3'b010);
    chk("full_ready", {31'b0, st_ready}, 32'h0);
    chk("full_count", 32'(count), 32'h4);
    drive(32'h314, 32'h5, 3'b010);
    idle(3);
    chk("full_hold", 32'(count), 32'h4);
    mem_wbusy = 1'b0;
    wait_accept();
    idle(6);

    store(32'h101, 32'h1111, 3'b001);
    chk("ill_sh_err", {31'b0, st_err}, 32'h1);
    chk("ill_sh_cnt", 32'(count), 32'h0);
    store(32'h102, 32'h2222, 3'b010);
    chk("ill_sw_err", {31'b0, st_err}, 32'h1);
    chk("ill_sw_strb", {31'b0, mem_wstrb}, 32'h0);
    store(32'h100, 32'h3333, 3'b011);
    chk("ill_f3_err", {31'b0, st_err}, 32'h1);
    store(32'h104, 32'h4444, 3'b111);
    chk("ill_f7_err", {31'b0, st_err}, 32'h1);
    chk("ill_cnt", 32'(count), 32'h0);
    idle(1);
    chk("err_clear", {31'b0, st_err}, 32'h0);

    t0 = cyc;
    for (int k = 0; k < 16; k++) begin
      store(32'h400 + 32'(4*k), $urandom, 3'b010);
      chk("stream_count", 32'(count), 32'h1);
    end
    chk("stream_cycles", 32'(cyc - t0), 32'd16);
    idle(2);

    repeat (300) begin
      mem_wbusy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0) begin
        drive($urandom & ($urandom_range(0, 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF),
              $urandom, 3'($urandom_range(0, 7)));
      end else begin
        st_valid = 1'b0;
      end
      idle(1);
    end
    st_valid  = 1'b0;
    mem_wbusy = 1'b0;
    idle(8);

    mem_wbusy = 1'b1;
    for (int i = 0; i < 3; i++) store(32'h500 + 32'(4*i), 32'hA0 + 32'(i), 3'b010);
    @(negedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk("arst_wstrb", {31'b0, mem_wstrb}, 32'h0);
    chk("arst_count", 32'(count), 32'h0);
    chk("arst_wmask", {28'b0, mem_wmask}, 32'h0);
    chk("arst_empty", {31'b0, empty}, 32'h1);
    @(negedge clk);
    #3;
    resetn    = 1'b1;
    mem_wbusy = 1'b0;
    idle(4);
    chk("post_rst_cnt", 32'(count), 32'h0);
    chk("post_rst_strb", {31'b0, mem_wstrb}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
